// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the reference-clocked PLL: holds RESETB, qualifies LOCK,
// releases the system reset after stable lock, retries failed attempts and falls back to bypass.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// HOLD      | PLL_RESETB low for RESET_HOLD_CYCLES, counters cleared
// WAIT_LOCK | PLL running, waiting for synchronised lock, timeout counting
// STABLE    | lock seen, counting consecutive lock cycles, timeout counting
// RUN       | stable lock, system reset released
// FAULT     | retries exhausted, PLL held in reset and bypassed
module pll_lock_sequencer #(
    parameter int RESET_HOLD_CYCLES   = 12,
    parameter int LOCK_TIMEOUT_CYCLES = 1200,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 2
) (
    input  logic               REFERENCECLK,
    input  logic               RESET,
    input  logic               PLL_LOCK,
    input  logic               RELOCK_REQ,
    output logic               PLL_RESETB,
    output logic               PLL_BYPASS,
    output logic               SYS_RESET,
    output logic               LOCKED,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_COUNT
);

    typedef enum logic [2:0] {
        S_HOLD, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0]   HOLD_TC   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t             state, state_nxt;
    logic               lock_meta, lock_s;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic [CNT_W-1:0]   to_cnt, to_nxt;
    logic [CNT_W-1:0]   stab_cnt, stab_nxt;
    logic [RETRY_W-1:0] retry, retry_nxt;
    logic               resetb_nxt, bypass_nxt, sys_reset_nxt, locked_nxt, fault_nxt;
    logic               timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign timeout     = (to_cnt == TIMEOUT_TC);
    assign RETRY_COUNT = retry;

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_HOLD;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            stab_cnt  <= '0;
            retry     <= '0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            to_cnt    <= to_nxt;
            stab_cnt  <= stab_nxt;
            retry     <= retry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        hold_nxt  = hold_cnt;
        to_nxt    = to_cnt;
        stab_nxt  = stab_cnt;
        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_TC) state_nxt = S_WAIT_LOCK;
                else                     hold_nxt  = sat_inc(hold_cnt);
            end
            S_WAIT_LOCK: begin
                to_nxt = sat_inc(to_cnt);
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (timeout) begin
                    if (retry == RETRY_MAX) state_nxt = S_FAULT;
                    else begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_STABLE: begin
                to_nxt = sat_inc(to_cnt);
                // reaching RUN beats a coincident timeout; a lock drop does not
                if (lock_s && stab_cnt == STABLE_TC) begin
                    state_nxt = S_RUN;
                end else if (timeout) begin
                    if (retry == RETRY_MAX) state_nxt = S_FAULT;
                    else begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = S_HOLD;
                    end
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else begin
                    stab_nxt = sat_inc(stab_cnt);
                end
            end
            S_RUN: begin
                if (!lock_s || RELOCK_REQ) begin
                    state_nxt = S_HOLD;
                    retry_nxt = '0;
                end
            end
            S_FAULT: begin
                if (RELOCK_REQ) begin
                    state_nxt = S_HOLD;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = S_HOLD;
        endcase
        if (state_nxt != state) begin
            if (state_nxt == S_HOLD) begin
                hold_nxt = '0;
                to_nxt   = '0;
            end
            if (state_nxt != S_RUN) stab_nxt = '0;
            if (state_nxt == S_WAIT_LOCK && state == S_HOLD) to_nxt = '0;
        end
    end

    always_comb begin
        resetb_nxt    = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                        (state_nxt == S_RUN);
        bypass_nxt    = (state_nxt == S_FAULT);
        sys_reset_nxt = (state_nxt != S_RUN);
        locked_nxt    = (state_nxt == S_RUN);
        fault_nxt     = (state_nxt == S_FAULT);
    end

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            PLL_RESETB <= 1'b0;
            PLL_BYPASS <= 1'b0;
            SYS_RESET  <= 1'b1;
            LOCKED     <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            PLL_RESETB <= resetb_nxt;
            PLL_BYPASS <= bypass_nxt;
            SYS_RESET  <= sys_reset_nxt;
            LOCKED     <= locked_nxt;
            FAULT      <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: stimulus pushes hand-computed output transitions (edge, value);
// a negedge monitor pops one entry per observed output change and compares it.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_resetb, pll_bypass, sys_reset, locked, fault;
    logic [1:0] retry_count;

    pll_lock_sequencer #(
        .RESET_HOLD_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16),
        .RETRY_W            (2)
    ) dut (
        .REFERENCECLK(clk),
        .RESET       (rst),
        .PLL_LOCK    (pll_lock),
        .RELOCK_REQ  (relock_req),
        .PLL_RESETB  (pll_resetb),
        .PLL_BYPASS  (pll_bypass),
        .SYS_RESET   (sys_reset),
        .LOCKED      (locked),
        .FAULT       (fault),
        .RETRY_COUNT (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [6:0] v;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         t0 = 0;
    int         checks = 0;
    int         errors = 0;
    logic [6:0] prev;

    // output vector: {RESETB, BYPASS, SYS_RESET, LOCKED, FAULT, RETRY_COUNT}
    function automatic logic [6:0] v_hold(input logic [1:0] r);
        return {5'b00100, r};
    endfunction
    function automatic logic [6:0] v_wait(input logic [1:0] r);
        return {5'b10100, r};
    endfunction
    function automatic logic [6:0] v_run(input logic [1:0] r);
        return {5'b10010, r};
    endfunction
    localparam logic [6:0] V_FAULT = 7'b0110110;

    function automatic logic [6:0] outs();
        return {pll_resetb, pll_bypass, sys_reset, locked, fault, retry_count};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int rel, input logic [6:0] v);
        exp_t e;
        e.edge_n = t0 + rel;
        e.v      = v;
        q.push_back(e);
    endtask

    task automatic at(input int rel);
        while (cyc < t0 + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic [6:0] want);
        checks++;
        if (outs() !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, outs(), want);
        end
    endtask

    task automatic relock();
        t0 = cyc;
        relock_req = 1'b1;
        at(1);
        relock_req = 1'b0;
    endtask

    initial prev = 7'b0010000;

    always @(negedge clk) begin
        logic [6:0] cur;
        exp_t       e;
        cur = outs();
        if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got %b at edge %0d", cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur !== e.v || cyc != e.edge_n) begin
                    errors++;
                    $display("FAIL transition got %b at edge %0d expected %b at edge %0d",
                             cur, cyc, e.v, e.edge_n);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_values", v_hold(2'd0));
        rst = 1'b0;
        t0  = cyc;

        // first lock: rises 5 cycles after RESETB, RUN 11 edges after first sample
        push(4, v_wait(2'd0));
        push(20, v_run(2'd0));
        at(8);
        pll_lock = 1'b1;
        at(25);

        // one-cycle lock drop in RUN
        t0 = cyc;
        pll_lock = 1'b0;
        at(1);
        pll_lock = 1'b1;
        push(3, v_hold(2'd0));
        push(7, v_wait(2'd0));
        push(17, v_run(2'd0));
        at(20);

        // relock from RUN; pulses in WAIT_LOCK and STABLE ignored
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        push(15, v_run(2'd0));
        at(5);  relock_req = 1'b1;
        at(6);  relock_req = 1'b0;
        at(8);  relock_req = 1'b1;
        at(9);  relock_req = 1'b0;
        at(20);

        // lock glitch at stable count 5, recovers inside timeout
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        push(23, v_run(2'd0));
        at(10); pll_lock = 1'b0;
        at(11); pll_lock = 1'b1;
        at(30);

        // RUN reached on the very timeout edge: RUN wins
        pll_lock = 1'b0;
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        push(25, v_run(2'd0));
        at(13); pll_lock = 1'b1;
        at(30);

        // one cycle later lock: timeout from STABLE, retry 1, then RUN with retry 1
        pll_lock = 1'b0;
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        push(25, v_hold(2'd1));
        push(29, v_wait(2'd1));
        push(39, v_run(2'd1));
        at(14); pll_lock = 1'b1;
        at(42);

        // no lock at all: three attempts then FAULT, lock ignored, relock recovers
        pll_lock = 1'b0;
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        push(25, v_hold(2'd1));
        push(29, v_wait(2'd1));
        push(49, v_hold(2'd2));
        push(53, v_wait(2'd2));
        push(73, V_FAULT);
        push(180, v_hold(2'd0));
        push(184, v_wait(2'd0));
        push(194, v_run(2'd0));
        at(100); pll_lock = 1'b1;
        at(179); relock_req = 1'b1;
        at(180); relock_req = 1'b0;
        at(200);

        // relock request coincident with lock loss in RUN
        t0 = cyc;
        pll_lock = 1'b0;
        push(3, v_hold(2'd0));
        push(7, v_wait(2'd0));
        push(17, v_run(2'd0));
        at(1); pll_lock = 1'b1;
        at(2); relock_req = 1'b1;
        at(3); relock_req = 1'b0;
        at(20);

        // async reset mid-STABLE
        relock();
        push(1, v_hold(2'd0));
        push(5, v_wait(2'd0));
        at(8);
        rst = 1'b1;
        push(8, v_hold(2'd0));
        #1;
        check_now("reset_mid_stable", v_hold(2'd0));
        at(10);
        rst = 1'b0;
        t0  = cyc;
        push(4, v_wait(2'd0));
        push(14, v_run(2'd0));
        at(20);

        // async reset mid-FAULT
        t0 = cyc;
        pll_lock = 1'b0;
        push(3, v_hold(2'd0));
        push(7, v_wait(2'd0));
        push(27, v_hold(2'd1));
        push(31, v_wait(2'd1));
        push(51, v_hold(2'd2));
        push(55, v_wait(2'd2));
        push(75, V_FAULT);
        at(80);
        rst = 1'b1;
        push(80, v_hold(2'd0));
        #1;
        check_now("reset_mid_fault", v_hold(2'd0));
        pll_lock = 1'b1;
        at(82);
        rst = 1'b0;
        t0  = cyc;
        push(4, v_wait(2'd0));
        push(14, v_run(2'd0));
        at(20);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_transitions got %0d left expected 0 (next edge %0d value %b)",
                     q.size(), q[0].edge_n, q[0].v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
